// File: rtl/uart_rx_sampler_pkg.sv
// Shared constants and helpers for the UART RX oversampling front end.
package uart_rx_pkg;

  localparam int unsigned EDGE_W = 6;
  localparam int unsigned BIT_W  = 4;

  localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

  localparam logic [BIT_W-1:0] BIT_CNT_MAX = 4'd15;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [EDGE_W-1:0] eff_prescale(input logic [EDGE_W-1:0] presc);
    logic [EDGE_W-1:0] p;
    case (presc)
      PRESCALE_16: p = PRESCALE_16;
      PRESCALE_32: p = PRESCALE_32;
      default:     p = PRESCALE_8;
    endcase
    return p;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Signals exchanged between the RX control FSM and the oversampling front end.
interface uart_rx_sampler_if #(
  parameter int unsigned EDGE_W = uart_rx_pkg::EDGE_W,
  parameter int unsigned BIT_W  = uart_rx_pkg::BIT_W
) ();

  logic              RX_IN;
  logic [5:0]        Prescale;
  logic              enable;
  logic              data_samp_en;
  logic [EDGE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sampled_bit;
  logic              samp_valid;

  modport master (
    output RX_IN, Prescale, enable, data_samp_en,
    input  edge_cnt, bit_cnt, sampled_bit, samp_valid
  );

  modport slave (
    input  RX_IN, Prescale, enable, data_samp_en,
    output edge_cnt, bit_cnt, sampled_bit, samp_valid
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge-within-bit and bit-within-frame counters with prescale legalization.
module uart_rx_edge_bit_cnt #(
  parameter int unsigned EDGE_W = uart_rx_pkg::EDGE_W,
  parameter int unsigned BIT_W  = uart_rx_pkg::BIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [5:0]        prescale_i,
  output logic [EDGE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]  bit_cnt_o,
  output logic [EDGE_W-1:0] mid_o,
  output logic              wrap_o
);
  import uart_rx_pkg::*;

  logic [EDGE_W-1:0] p_eff;
  logic [EDGE_W-1:0] p_last;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  assign p_eff  = EDGE_W'(eff_prescale(prescale_i));
  assign p_last = p_eff - EDGE_W'(1);
  assign mid_o  = p_eff >> 1;

  // >= rather than == so a prescale shrink mid-bit wraps instead of running away.
  assign wrap_o = enable_i && (edge_q >= p_last);

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (!enable_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (wrap_o) begin
      edge_d = '0;
      if (bit_q != BIT_W'(BIT_CNT_MAX)) begin
        bit_d = bit_q + 1'b1;
      end
    end else begin
      edge_d = edge_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end: counters plus three-sample mid-bit majority vote.
module uart_rx_sampler #(
  parameter int unsigned EDGE_W = uart_rx_pkg::EDGE_W,
  parameter int unsigned BIT_W  = uart_rx_pkg::BIT_W
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_sampler_if.slave  bus
);
  import uart_rx_pkg::*;

  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] mid;
  logic [BIT_W-1:0]  bit_cnt;
  logic              wrap;
  logic              capture;

  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic sampled_q, sampled_d;
  logic valid_q, valid_d;

  uart_rx_edge_bit_cnt #(
    .EDGE_W (EDGE_W),
    .BIT_W  (BIT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (bus.enable),
    .prescale_i (bus.Prescale),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .mid_o      (mid),
    .wrap_o     (wrap)
  );

  assign capture = bus.enable && bus.data_samp_en;

  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    sampled_d = sampled_q;
    valid_d   = 1'b0;
    if (capture) begin
      if (edge_cnt == mid - EDGE_W'(2)) begin
        s0_d = bus.RX_IN;
      end
      if (edge_cnt == mid - EDGE_W'(1)) begin
        s1_d = bus.RX_IN;
      end
      // Third sample is the live line value, so the vote lands on the mid edge itself.
      if (edge_cnt == mid) begin
        s2_d      = bus.RX_IN;
        sampled_d = maj3(s0_q, s1_q, s2_d);
        valid_d   = 1'b1;
      end
    end
    if (wrap) begin
      s0_d = 1'b1;
      s1_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sampled_q <= sampled_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.sampled_bit = sampled_q;
  assign bus.samp_valid  = valid_q;

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receiver: tracks edge position within each bit period and bit position within the frame, and majority-votes three mid-bit samples of the serial line. Sits directly upstream of the UART RX control FSM. Feeds it `edge_cnt`, `bit_cnt` and the voted bit, and takes `enable` / `data_samp_en` back from it.

## Interface
- `EDGE_W`, 6: edge-counter width; holds values up to Prescale-1 = 31.
- `BIT_W`, 4: bit-counter width.
- `clk` in 1: receiver oversampling clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `RX_IN` in 1: serial line, already synchronous to `clk` via a two-flop synchronizer outside this block; idles high.
- `Prescale` in 6: oversampling ratio. Legal values are 8, 16 and 32. Any other value is treated as 8.
- `enable` in 1: from FSM; counters run while high.
- `data_samp_en` in 1: from FSM; sample capture and vote are allowed while high.
- `edge_cnt` out EDGE_W: position within the current bit, 0..Prescale-1.
- `bit_cnt` out BIT_W: index of the current bit in the frame (start bit = 0).
- `sampled_bit` out 1: last majority-vote result.
- `samp_valid` out 1: one-cycle pulse; `sampled_bit` was updated this cycle.

## Operation
- Effective prescale P = Prescale if in {8,16,32}, else 8. The mid-point is M = P/2.
- Edge counter, while `enable`=1:
  - increments by 1 each cycle;
  - when `edge_cnt` >= P-1, it wraps to 0 and `bit_cnt` increments.
- `bit_cnt` saturates at 15; it never wraps to 0 on its own.
- When `enable`=0, `edge_cnt` and `bit_cnt` go to 0 on the next edge. Clearing takes priority over increment and wrap.
- Sampling, while `data_samp_en`=1 and `enable`=1:
  - capture `RX_IN` into s0 at `edge_cnt`=M-2, into s1 at M-1, and into s2 at M;
  - in the cycle `edge_cnt`=M, register `sampled_bit` <= maj(s0, s1, `RX_IN`) and set `samp_valid`=1 for one cycle.
- If `data_samp_en` is low at `edge_cnt`=M, there is no vote and no pulse for that bit; `sampled_bit` holds.
- s0/s1 clear to 1 on every bit wrap, so stale samples never mix across bits.
- Reset values: `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, `samp_valid`=0, s0=s1=1.
- Reset mid-frame returns all state to these values immediately (asynchronous). Counting resumes only once `enable` is seen high after reset release.
- A Prescale change mid-frame takes effect on the next cycle. If `edge_cnt` is then >= new P-1, it wraps on that cycle (the >= compare guarantees there is no runaway count).

## Timing
- All outputs are registered; there is no combinational path from input to output.
- The first increment happens on the first rising edge with `enable`=1: `edge_cnt` reads 1 after that edge.
- Vote latency: `sampled_bit`/`samp_valid` are visible one cycle after the cycle where `edge_cnt`=M. At that point `edge_cnt` reads M+1.
- The FSM sees the voted bit well before the bit boundary for every legal P. The worst case is P=8: voted bit available at edge 5 of 0..7.
- One bit period is exactly P cycles; an N-bit frame is N·P cycles of `enable`.

## Structure
- Package `uart_rx_pkg` holds:
  - constants PRESCALE_8/16/32, `EDGE_W`, `BIT_W`, `BIT_CNT_MAX`=15;
  - a function `eff_prescale` (legalizes Prescale);
  - a function `maj3`.
- One natural sub-module: `uart_rx_edge_bit_cnt`, containing the edge and bit counters, clear/wrap/saturate logic and the P legalization. The sampling registers and vote stay in `uart_rx_sampler`.

## Test plan
- P=8, enable held 10 bit periods, RX_IN=0 for bit 0 then alternating 1/0:
  - `edge_cnt` cycles 0..7;
  - `bit_cnt` 0..9;
  - `samp_valid` pulses at `edge_cnt`=5 of each bit;
  - `sampled_bit` sequence is 0,1,0,1,...
- P=16, glitch RX_IN=1 for exactly one cycle at `edge_cnt`=7 of a 0 bit → `sampled_bit`=0. Then two cycles high at edges 6–7 → `sampled_bit`=1.
- P=32 and P=13 (illegal):
  - P=32: wrap at 31, vote at edge 16;
  - P=13: behaves exactly as P=8.
- `enable` dropped at `edge_cnt`=3, `bit_cnt`=4 → both read 0 next cycle, and no `samp_valid`. Re-enabled → count restarts from 0.
- Hold `enable` 20 bit periods at P=8 → `bit_cnt` saturates at 15 and stays 15.
- Assert `rst` mid-vote (`edge_cnt`=M-1, P=16) → all outputs at reset values within the same cycle, with no `samp_valid` after release. Also: P switched 32→8 while `edge_cnt`=20 → `edge_cnt`=0 and `bit_cnt`+1 next cycle.
